rcc_scan_mode_seq: RTL and testbench



---
 rtl/rcc_pkg.sv | 35 +++
 rtl/rcc_sync_bit.sv | 35 +++
 rtl/rcc_scan_mode_seq.sv | 185 ++++++++++++++++++
 tb/tb_rcc_scan_mode_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_pkg.sv
// -----------------------------------------------------------------------------
// rcc_pkg
// Shared definitions for the RCC scan-mode sequencer and its helpers:
//   - seq_state_e : sequencer states (two steady states, three switch phases)
//   - DEF_*       : default parameter values used by the RCC blocks
//   - max_int / seq_cnt_width : sizing helpers for the shared phase counter
// -----------------------------------------------------------------------------
package rcc_pkg;

   typedef enum logic [2:0] {
      FUNC     = 3'd0,
      TEST     = 3'd1,
      GATE_OFF = 3'd2,
      SETTLE   = 3'd3,
      GATE_ON  = 3'd4
   } seq_state_e;

   localparam int DEF_NUM_CLK       = 16;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_SETTLE_CYCLES = 8;
   localparam int DEF_ACK_TIMEOUT   = 255;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One counter serves both the ack wait and the settle interval, so it is
   // sized for the larger of the two terminal values; never narrower than 1.
   function automatic int seq_cnt_width(input int ack_timeout, input int settle_cycles);
      int w;
      w = $clog2(max_int(ack_timeout, settle_cycles));
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rcc_sync_bit.sv
// -----------------------------------------------------------------------------
// rcc_sync_bit
// N-stage synchronizer for a single asynchronous level. All stages clear on
// rst_n, so the synchronized output reads 0 straight out of reset.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronized level (last flop of the chain)
// -----------------------------------------------------------------------------
module rcc_sync_bit
   import rcc_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous level through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/rcc_scan_mode_seq.sv
// -----------------------------------------------------------------------------
// rcc_scan_mode_seq
// Glitch-safe sequencer for the RCC test-clock muxes. A change of the
// synchronized testmode level closes every functional clock gate, waits for the
// gates to report closed (or times out), flips scan_mode, waits a settle
// interval, reopens the gates and waits for them to report open.
// Ports:
//   clk         : always-on sequencer clock
//   rst_n       : asynchronous active-low reset
//   testmode    : asynchronous test request level from the pad
//   gate_ack    : per-clock "gate closed" status, synchronous to clk
//   err_clr     : clears seq_err (a simultaneous timeout keeps it set)
//   scan_mode   : select for all test clock muxes
//   clk_gate_en : per-clock gate enable, 1 = functional clock running
//   busy        : high while a switch sequence is in progress
//   done        : one-cycle pulse when a sequence completes
//   seq_err     : sticky ack-timeout flag
// -----------------------------------------------------------------------------
module rcc_scan_mode_seq
   import rcc_pkg::*;
#(
   parameter int NUM_CLK       = DEF_NUM_CLK,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               testmode,
   input  logic [NUM_CLK-1:0] gate_ack,
   input  logic               err_clr,
   output logic               scan_mode,
   output logic [NUM_CLK-1:0] clk_gate_en,
   output logic               busy,
   output logic               done,
   output logic               seq_err
);

   localparam int CW = seq_cnt_width(ACK_TIMEOUT, SETTLE_CYCLES);

   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = CW'(32'd1);
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
   localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 32'sd1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 32'sd1);

   localparam logic [NUM_CLK-1:0] GATES_ON  = {NUM_CLK{1'b1}};
   localparam logic [NUM_CLK-1:0] GATES_OFF = {NUM_CLK{1'b0}};

   seq_state_e         state_r,   state_nxt;
   logic [CW-1:0]      cnt_r,     cnt_nxt;
   logic               scan_mode_r, scan_nxt;
   logic [NUM_CLK-1:0] gate_en_r, gate_en_nxt;
   logic               busy_r,    busy_nxt;
   logic               done_r,    done_nxt;
   logic               err_r,     err_nxt;

   logic               testmode_s;
   logic               timeout_s;
   logic [CW-1:0]      cnt_inc_s;
   logic [CW-1:0]      cnt_dec_s;

   rcc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_testmode_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (testmode),
      .q     (testmode_s)
   );

   // The counter saturates in both directions instead of wrapping.
   assign cnt_inc_s = (cnt_r == CNT_MAX)  ? cnt_r : (cnt_r + CNT_ONE);
   assign cnt_dec_s = (cnt_r == CNT_ZERO) ? cnt_r : (cnt_r - CNT_ONE);

   // Next-state and next-output decode. scan_mode only flips on the
   // GATE_OFF exit, where every gate enable is already 0.
   always_comb begin
      state_nxt   = state_r;
      cnt_nxt     = cnt_r;
      scan_nxt    = scan_mode_r;
      gate_en_nxt = gate_en_r;
      busy_nxt    = busy_r;
      done_nxt    = 1'b0;
      timeout_s   = 1'b0;

      case (state_r)
         FUNC, TEST: begin
            // testmode_s is looked at only here, so requests that arrive
            // mid-sequence wait until the running sequence finishes.
            if (testmode_s != scan_mode_r) begin
               state_nxt   = GATE_OFF;
               cnt_nxt     = CNT_ZERO;
               gate_en_nxt = GATES_OFF;
               busy_nxt    = 1'b1;
            end else begin
               gate_en_nxt = GATES_ON;
               busy_nxt    = 1'b0;
            end
         end

         GATE_OFF: begin
            if ((&gate_ack) || (cnt_r == ACK_LAST)) begin
               // Ack wins over a coincident timeout.
               timeout_s = ~(&gate_ack);
               scan_nxt  = ~scan_mode_r;
               cnt_nxt   = SETTLE_LOAD;
               state_nxt = SETTLE;
            end else begin
               cnt_nxt = cnt_inc_s;
            end
         end

         SETTLE: begin
            if (cnt_r == CNT_ZERO) begin
               state_nxt   = GATE_ON;
               cnt_nxt     = CNT_ZERO;
               gate_en_nxt = GATES_ON;
            end else begin
               cnt_nxt = cnt_dec_s;
            end
         end

         GATE_ON: begin
            if ((~|gate_ack) || (cnt_r == ACK_LAST)) begin
               timeout_s = |gate_ack;
               state_nxt = scan_mode_r ? TEST : FUNC;
               cnt_nxt   = CNT_ZERO;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt_inc_s;
            end
         end

         default: begin
            // Unreachable encoding: settle into the steady state that matches
            // the current select without touching scan_mode.
            state_nxt   = scan_mode_r ? TEST : FUNC;
            cnt_nxt     = CNT_ZERO;
            gate_en_nxt = GATES_ON;
            busy_nxt    = 1'b0;
         end
      endcase
   end

   // Sticky error flag: a timeout in the same cycle beats err_clr.
   always_comb begin
      if (timeout_s) begin
         err_nxt = 1'b1;
      end else if (err_clr) begin
         err_nxt = 1'b0;
      end else begin
         err_nxt = err_r;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= FUNC;
         cnt_r       <= CNT_ZERO;
         scan_mode_r <= 1'b0;
         gate_en_r   <= GATES_ON;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         scan_mode_r <= scan_nxt;
         gate_en_r   <= gate_en_nxt;
         busy_r      <= busy_nxt;
         done_r      <= done_nxt;
         err_r       <= err_nxt;
      end
   end

   assign scan_mode   = scan_mode_r;
   assign clk_gate_en = gate_en_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign seq_err     = err_r;

endmodule

// File: tb/tb_rcc_scan_mode_seq.sv
// -----------------------------------------------------------------------------
// tb_rcc_scan_mode_seq
// Directed bench for rcc_scan_mode_seq (NUM_CLK=16, SYNC_STAGES=2,
// SETTLE_CYCLES=4, ACK_TIMEOUT=16). Each switch request pushes the expected
// end-of-sequence outputs into a queue; a monitor pops and compares on every
// done pulse. A gate-cell responder answers clk_gate_en with programmable delay.
// -----------------------------------------------------------------------------
module tb_rcc_scan_mode_seq;

   localparam int NCLK = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            testmode = 1'b0;
   logic            err_clr = 1'b0;
   logic [NCLK-1:0] gate_ack = 16'h0000;
   logic            scan_mode;
   logic [NCLK-1:0] clk_gate_en;
   logic            busy;
   logic            done;
   logic            seq_err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic scan;
      logic err;
   } exp_t;
   exp_t sb[$];

   logic            ack_force = 1'b0;
   logic [NCLK-1:0] ack_force_val = 16'h0000;
   int              dly_off = 0;
   int              dly_on = 0;
   logic            glitch_mask = 1'b0;

   always #5 clk = ~clk;

   rcc_scan_mode_seq #(
      .NUM_CLK       (16),
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (4),
      .ACK_TIMEOUT   (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .testmode    (testmode),
      .gate_ack    (gate_ack),
      .err_clr     (err_clr),
      .scan_mode   (scan_mode),
      .clk_gate_en (clk_gate_en),
      .busy        (busy),
      .done        (done),
      .seq_err     (seq_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait until no sequence is running, all expectations are consumed and the
   // gate cells report open; returns at negedge+1.
   task automatic wait_idle(input int budget, input string name);
      int   n;
      logic idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         idle = (busy === 1'b0) && (sb.size() == 0) && (gate_ack === 16'h0000);
      end
      check(name, 32'(idle), 32'd1);
   endtask

   // Gate-cell model: d negedges after clk_gate_en changes, report the gates.
   initial begin : responder
      logic [NCLK-1:0] last_en;
      int              cnt;
      bit              pending;
      last_en = 16'hFFFF;
      cnt = 0;
      pending = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_force) begin
            gate_ack = ack_force_val;
            last_en  = ~clk_gate_en;
            pending  = 1'b0;
         end else if (clk_gate_en != last_en) begin
            last_en = clk_gate_en;
            cnt     = (clk_gate_en == 16'h0000) ? dly_off : dly_on;
            pending = 1'b1;
            if (cnt == 0) begin
               gate_ack = (last_en == 16'h0000) ? 16'hFFFF : 16'h0000;
               pending  = 1'b0;
            end
         end else if (pending) begin
            cnt--;
            if (cnt == 0) begin
               gate_ack = (last_en == 16'h0000) ? 16'hFFFF : 16'h0000;
               pending  = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every done pulse consumes one expectation.
   initial begin : monitor
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            check("done_width", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_scan_mode", 32'(scan_mode), 32'(e.scan));
               check("sb_seq_err", 32'(seq_err), 32'(e.err));
               check("sb_gate_en", 32'(clk_gate_en), 32'h0000FFFF);
               check("sb_busy", 32'(busy), 32'd0);
            end
         end
         prev_done = done;
      end
   end

   // scan_mode may only move while every gate enable is 0 before and after.
   initial begin : glitch_mon
      logic            prev_scan;
      logic [NCLK-1:0] prev_gate;
      prev_scan = 1'b0;
      prev_gate = 16'hFFFF;
      forever begin
         @(negedge clk);
         if (!glitch_mask && (scan_mode !== prev_scan)) begin
            check("glitch", 32'(prev_gate | clk_gate_en), 32'd0);
         end
         prev_scan = scan_mode;
         prev_gate = clk_gate_en;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int   i_s;
      int   i_g;
      int   n;
      int   dc0;
      logic tm;
      logic err_exp;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_scan_mode", 32'(scan_mode), 32'd0);
      check("rst_gate_en", 32'(clk_gate_en), 32'h0000FFFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1. Entry: ack 3 cycles after gates drop, release 1 cycle after rise
      dly_off = 3;
      dly_on  = 1;
      dc0 = done_cnt;
      sb.push_back('{scan: 1'b1, err: 1'b0});
      testmode = 1'b1;
      @(negedge clk);
      check("t1_gate_edge0", 32'(clk_gate_en), 32'h0000FFFF);
      @(negedge clk);
      check("t1_gate_edge1", 32'(clk_gate_en), 32'h0000FFFF);
      @(negedge clk);
      check("t1_gate_edge2", 32'(clk_gate_en), 32'h00000000);
      check("t1_busy_edge2", 32'(busy), 32'd1);
      i_s = -1;
      i_g = -1;
      for (int i = 0; i < 60 && i_g < 0; i++) begin
         @(negedge clk);
         if (scan_mode === 1'b1 && i_s < 0) i_s = i;
         if (clk_gate_en === 16'hFFFF && i_g < 0) i_g = i;
      end
      check("t1_scan_edge", 32'(i_s), 32'd3);
      check("t1_settle_gap", 32'(i_g - i_s), 32'd4);
      wait_idle(100, "t1_idle");
      check("t1_done_count", 32'(done_cnt - dc0), 32'd1);
      check("t1_seq_err", 32'(seq_err), 32'd0);

      // 2. Exit back to FUNC
      @(negedge clk);
      dc0 = done_cnt;
      sb.push_back('{scan: 1'b0, err: 1'b0});
      testmode = 1'b0;
      wait_idle(100, "t2_idle");
      check("t2_scan_mode", 32'(scan_mode), 32'd0);
      check("t2_done_count", 32'(done_cnt - dc0), 32'd1);

      // 3. Timeout with one gate never acknowledging
      @(negedge clk);
      ack_force_val = 16'h7FFF;
      ack_force = 1'b1;
      sb.push_back('{scan: 1'b1, err: 1'b1});
      testmode = 1'b1;
      n = 0;
      while (clk_gate_en !== 16'h0000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t3_gate_drop", 32'(n < 20), 32'd1);
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (scan_mode === 1'b0) n++;
      end
      check("t3_hold_cycles", 32'(n), 32'd15);
      @(negedge clk);
      check("t3_scan_toggle", 32'(scan_mode), 32'd1);
      check("t3_seq_err_set", 32'(seq_err), 32'd1);
      ack_force = 1'b0;
      dly_off = 1;
      dly_on  = 1;
      wait_idle(100, "t3_idle");
      check("t3_err_sticky", 32'(seq_err), 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t3_err_cleared", 32'(seq_err), 32'd0);
      sb.push_back('{scan: 1'b0, err: 1'b0});
      testmode = 1'b0;
      wait_idle(100, "t3_exit_idle");

      // 4. Request flips back during SETTLE: two back-to-back sequences
      @(negedge clk);
      dly_off = 2;
      dly_on  = 2;
      dc0 = done_cnt;
      sb.push_back('{scan: 1'b1, err: 1'b0});
      sb.push_back('{scan: 1'b0, err: 1'b0});
      testmode = 1'b1;
      n = 0;
      while (scan_mode !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t4_reach_settle", 32'(scan_mode), 32'd1);
      testmode = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("t4_first_done", 32'(done), 32'd1);
      check("t4_busy_gap", 32'(busy), 32'd0);
      @(negedge clk);
      #1;
      check("t4_restart", 32'(busy), 32'd1);
      wait_idle(150, "t4_idle");
      check("t4_done_count", 32'(done_cnt - dc0), 32'd2);
      check("t4_scan_mode", 32'(scan_mode), 32'd0);

      // 5. Asynchronous reset during SETTLE
      @(negedge clk);
      testmode = 1'b1;
      n = 0;
      while (scan_mode !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t5_reach_settle", 32'(scan_mode), 32'd1);
      glitch_mask = 1'b1;
      #2;
      testmode = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5_rst_scan_mode", 32'(scan_mode), 32'd0);
      check("t5_rst_gate_en", 32'(clk_gate_en), 32'h0000FFFF);
      check("t5_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      glitch_mask = 1'b0;
      wait_idle(100, "t5_idle");
      check("t5_after_scan", 32'(scan_mode), 32'd0);
      check("t5_after_gate", 32'(clk_gate_en), 32'h0000FFFF);

      // 6. 200 switches with random ack delays 0..20
      tm = 1'b0;
      err_exp = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         dly_off = int'($urandom_range(0, 20));
         dly_on  = int'($urandom_range(0, 20));
         if (dly_off >= 16 || dly_on >= 16) err_exp = 1'b1;
         tm = ~tm;
         sb.push_back('{scan: tm, err: err_exp});
         testmode = tm;
         wait_idle(200, "t6_idle");
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
